// File: rtl/blink_pkg.sv
// blink_pkg: shared FSM state and mode encodings for the blink sequencer
package blink_pkg;
    typedef enum logic [2:0] {IDLE, ON, BLINK, BURST_ON, BURST_OFF, PAUSE} state_t;
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..TICK_CYCLES-1 while enabled and pulses tick on the last count
//   CLOCK_50 clock, KEY async active-low reset, en count enable,
//   clr sync clear (priority over en), tick one-cycle pulse at end of each period
module tick_prescaler #(
    parameter int TICK_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic CLOCK_50,
    input  logic KEY,
    input  logic en,
    input  logic clr,
    output logic tick
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    assign w_last = r_cnt == CNT_W'(TICK_CYCLES - 1);
    assign tick   = en && w_last;
    always_ff @(posedge CLOCK_50 or negedge KEY)
        if (!KEY)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: started/stoppable LED sequencer (off, steady, blink, bursts with pauses)
//   CLOCK_50 clock, KEY async active-low reset, mode/burst_len/pause_ticks latched on start,
//   start/stop request pulses, tick prescaler pulse while busy, LEDG registered LED drive,
//   busy high outside IDLE, done pulse at end of each burst group or on a zero-length burst
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int CNT_W       = 26,
    parameter int LEN_W       = 4
) (
    input  logic             CLOCK_50,
    input  logic             KEY,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [LEN_W-1:0] pause_ticks,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             LEDG,
    output logic             busy,
    output logic             done
);
    state_t           r_state;
    logic             r_led;
    logic             r_done;
    logic [LEN_W-1:0] r_blink;
    logic [LEN_W-1:0] r_pause;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_pt;
    logic             w_busy;
    logic             w_tick;
    logic [LEN_W-1:0] w_blink_nxt;
    logic [LEN_W-1:0] w_pause_nxt;
    logic             w_group_end;
    assign w_busy      = r_state != IDLE;
    assign w_blink_nxt = r_blink + 1'b1;
    assign w_pause_nxt = r_pause + 1'b1;
    assign w_group_end = r_state == BURST_OFF && w_tick && w_blink_nxt >= r_len;
    assign tick        = w_tick;
    assign LEDG        = r_led;
    assign busy        = w_busy;
    // group-end done must land in the tick cycle itself; a stop in that cycle suppresses it
    assign done        = r_done | (w_group_end && !stop);

    // held clear throughout IDLE so every start sees a fresh full tick period
    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES),
        .CNT_W      (CNT_W)
    ) u_prescaler (
        .CLOCK_50(CLOCK_50),
        .KEY     (KEY),
        .en      (w_busy),
        .clr     (!w_busy || stop),
        .tick    (w_tick)
    );

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_state <= IDLE;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
            r_blink <= '0;
            r_pause <= '0;
            r_len   <= '0;
            r_pt    <= '0;
        end else begin
            r_done <= 1'b0;
            // stop beats everything, including a simultaneous start in IDLE
            if (stop) begin
                r_state <= IDLE;
                r_led   <= 1'b0;
                r_blink <= '0;
                r_pause <= '0;
            end else begin
                case (r_state)
                    IDLE: if (start) begin
                        r_len <= burst_len;
                        r_pt  <= pause_ticks;
                        case (mode)
                            MODE_ON: begin
                                r_state <= ON;
                                r_led   <= 1'b1;
                            end
                            MODE_BLINK: begin
                                r_state <= BLINK;
                                r_led   <= 1'b1;
                            end
                            MODE_BURST: if (burst_len == '0)
                                r_done <= 1'b1;
                            else begin
                                r_state <= BURST_ON;
                                r_led   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    ON: ;
                    BLINK: if (w_tick) r_led <= ~r_led;
                    BURST_ON: if (w_tick) begin
                        r_state <= BURST_OFF;
                        r_led   <= 1'b0;
                    end
                    BURST_OFF: if (w_tick) begin
                        if (w_blink_nxt < r_len) begin
                            r_blink <= w_blink_nxt;
                            r_state <= BURST_ON;
                            r_led   <= 1'b1;
                        end else begin
                            r_blink <= '0;
                            if (r_pt != '0)
                                r_state <= PAUSE;
                            else begin
                                r_state <= BURST_ON;
                                r_led   <= 1'b1;
                            end
                        end
                    end
                    PAUSE: if (w_tick) begin
                        if (w_pause_nxt == r_pt) begin
                            r_pause <= '0;
                            r_state <= BURST_ON;
                            r_led   <= 1'b1;
                        end else
                            r_pause <= w_pause_nxt;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: scoreboard bench; expected {LEDG,busy,tick,done} per cycle queued with stimulus
module tb_blink_sequencer;
    logic       clk = 1'b0;
    logic       KEY = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] burst_len = '0;
    logic [3:0] pause_ticks = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       tick, LEDG, busy, done;
    int         n_chk = 0;
    int         n_err = 0;

    typedef struct {
        string      tag;
        logic [3:0] v;
    } exp_t;
    exp_t q[$];

    blink_sequencer #(.TICK_CYCLES(4), .CNT_W(3), .LEN_W(4)) dut (
        .CLOCK_50   (clk),
        .KEY        (KEY),
        .mode       (mode),
        .burst_len  (burst_len),
        .pause_ticks(pause_ticks),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .LEDG       (LEDG),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: {LEDG,busy,tick,done} got %b expected %b", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.tag, {LEDG, busy, tick, done}, e.v);
        end

    // one cycle: drive start/stop just after the edge, queue what the outputs must be this cycle
    task automatic cyc(input string tag, input logic s, input logic p, input logic [3:0] e);
        @(posedge clk);
        #1;
        start = s;
        stop  = p;
        q.push_back('{tag, e});
    endtask

    function automatic logic [3:0] exp_blink(input int c);
        logic led, tk;
        if (c == 0) return 4'b0000;
        led = ((c - 1) / 4) % 2 == 0;
        tk  = c % 4 == 0;
        return {led, 1'b1, tk, 1'b0};
    endfunction

    // burst_len=2: on 4, off 4, on 4, off 4, then pause of 4*pause_ticks; period P cycles
    function automatic logic [3:0] exp_burst(input int c, input int per);
        int   ph;
        logic led, tk, dn;
        if (c == 0) return 4'b0000;
        ph  = (c - 1) % per;
        led = ph < 4 || (ph >= 8 && ph < 12);
        tk  = c % 4 == 0;
        dn  = ph == 15;
        return {led, 1'b1, tk, dn};
    endfunction

    task automatic run_blink(input string nm);
        mode = 2'b10;
        cyc($sformatf("%s c0", nm), 1'b1, 1'b0, 4'b0000);
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) mode = 2'b01;
            cyc($sformatf("%s c%0d", nm, c), c == 3, c == 14, exp_blink(c));
        end
        cyc($sformatf("%s stopped", nm), 1'b0, 1'b0, 4'b0000);
        cyc($sformatf("%s idle", nm), 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic run_burst(input string nm, input logic [3:0] pt, input int per);
        mode        = 2'b11;
        burst_len   = 4'd2;
        pause_ticks = pt;
        cyc($sformatf("%s c0", nm), 1'b1, 1'b0, 4'b0000);
        for (int c = 1; c <= 25; c++) begin
            if (c == 2) begin
                burst_len   = 4'd5;
                pause_ticks = 4'd3;
            end
            cyc($sformatf("%s c%0d", nm, c), 1'b0, c == 25, exp_burst(c, per));
        end
        cyc($sformatf("%s stopped", nm), 1'b0, 1'b0, 4'b0000);
    endtask

    initial begin
        for (int c = 0; c < 3; c++) cyc($sformatf("reset held c%0d", c), 1'b0, 1'b0, 4'b0000);
        KEY = 1'b1;
        for (int c = 0; c < 3; c++) cyc($sformatf("reset released c%0d", c), 1'b0, 1'b0, 4'b0000);

        run_blink("blink");
        run_burst("burst p1", 4'd1, 20);
        run_burst("burst p0", 4'd0, 16);

        mode = 2'b10;
        cyc("stopstart c0", 1'b1, 1'b0, 4'b0000);
        for (int c = 1; c <= 5; c++) cyc($sformatf("stopstart c%0d", c), 1'b0, 1'b0, exp_blink(c));
        cyc("stopstart c6", 1'b1, 1'b1, exp_blink(6));
        for (int c = 7; c <= 9; c++) cyc($sformatf("stopstart c%0d", c), 1'b0, 1'b0, 4'b0000);
        mode = 2'b01;
        cyc("steady c0", 1'b1, 1'b0, 4'b0000);
        for (int c = 1; c <= 13; c++)
            cyc($sformatf("steady c%0d", c), 1'b0, c == 13, {1'b1, 1'b1, c % 4 == 0, 1'b0});
        cyc("steady stopped", 1'b0, 1'b0, 4'b0000);

        mode      = 2'b11;
        burst_len = 4'd0;
        cyc("zero burst c0", 1'b1, 1'b0, 4'b0000);
        cyc("zero burst c1", 1'b0, 1'b0, 4'b0001);
        cyc("zero burst c2", 1'b0, 1'b0, 4'b0000);
        cyc("zero burst c3", 1'b0, 1'b0, 4'b0000);

        mode        = 2'b11;
        burst_len   = 4'd3;
        pause_ticks = 4'd2;
        cyc("midreset c0", 1'b1, 1'b0, 4'b0000);
        cyc("midreset c1", 1'b0, 1'b0, 4'b1100);
        cyc("midreset c2", 1'b0, 1'b0, 4'b1100);
        @(posedge clk);
        #1;
        #1 KEY = 1'b0;
        q.push_back('{"midreset async", 4'b0000});
        cyc("midreset held", 1'b0, 1'b0, 4'b0000);
        KEY = 1'b1;
        cyc("midreset released", 1'b0, 1'b0, 4'b0000);
        run_blink("blink after reset");

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
